// File: rtl/regfile_sb_if.sv
// Issue/read/writeback bus of the regfile_sb integer register file.
// The master side is the core pipeline; the slave side is the register file.
interface regfile_sb_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*XLEN-1:0]   rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [XLEN-1:0]          wdata;
  logic                     issue_valid;
  logic [ADDR_W-1:0]        issue_rd;

  modport master (
    output rd_addr, we, waddr, wdata, issue_valid, issue_rd,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, we, waddr, wdata, issue_valid, issue_rd,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised integer register file with x0 hardwired to zero, busy scoreboard and post-reset clear sweep.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic         clk,
  input  logic         reset,
  output logic         init_done,
  regfile_sb_if.slave  bus
);
  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NREGS - 1);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              init_done_q, init_done_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   mem_q [NREGS];
  logic [XLEN-1:0]   mem_d [NREGS];

  logic              wr_ok;
  logic              iss_ok;
  logic [ADDR_W-1:0] ra;

  assign wr_ok     = init_done_q && bus.we && (bus.waddr != '0);
  assign iss_ok    = init_done_q && bus.issue_valid && (bus.issue_rd != '0);
  assign init_done = init_done_q;

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    init_done_d = init_done_q;
    busy_d      = busy_q;
    mem_d       = mem_q;
    case (state_q)
      CLEAR: begin
        mem_d[clr_ptr_q] = '0;
        if (clr_ptr_q == LAST_PTR) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      RUN: begin
        if (wr_ok) begin
          mem_d[bus.waddr]  = bus.wdata;
          busy_d[bus.waddr] = 1'b0;
        end
        // Set after clear so a new producer keeps the register reserved.
        if (iss_ok) begin
          busy_d[bus.issue_rd] = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
    busy_d[0] = 1'b0;
  end

  // The array has no reset; the clear sweep zeroes it instead.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= ADDR_W'(1);
      init_done_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    ra          = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra = bus.rd_addr[p*ADDR_W +: ADDR_W];
      if (init_done_q && (ra != '0)) begin
        bus.rd_data[p*XLEN +: XLEN] = mem_q[ra];
        bus.rd_busy[p]              = busy_q[ra];
      end
`ifdef REGFILE_BYPASS_EN
      // Forwarded write clears busy unless the same register is being re-reserved.
      if (wr_ok && (ra == bus.waddr)) begin
        bus.rd_data[p*XLEN +: XLEN] = bus.wdata;
        if (!(bus.issue_valid && (bus.issue_rd == bus.waddr))) begin
          bus.rd_busy[p] = 1'b0;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb with four read ports.
module tb_regfile_sb;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset;
  logic init_done;
  int   total = 0;
  int   bad   = 0;

  regfile_sb_if #(.XLEN(32), .ADDR_W(5), .NUM_RD(4)) bus ();

  regfile_sb #(.XLEN(32), .ADDR_W(5), .NUM_RD(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .init_done (init_done),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rdData(input int p);
    return bus.rd_data[p*32 +: 32];
  endfunction

  function automatic logic [31:0] rdBusy(input int p);
    return 32'(bus.rd_busy[p]);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic iv, input logic [4:0] ir);
    bus.we          = w;
    bus.waddr       = wa;
    bus.wdata       = wd;
    bus.issue_valid = iv;
    bus.issue_rd    = ir;
  endtask

  task automatic setReads(input logic [4:0] a0, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] a3);
    bus.rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    setReads(5'd5, 5'd4, 5'd0, 5'd0);
    tick;
    tick;
    checkOutput("reset_init_done", 32'(init_done), 32'd0);
    checkOutput("reset_rd_data0", rdData(0), 32'd0);
    checkOutput("reset_rd_busy0", rdBusy(0), 32'd0);

    // First sweep, with writes and reservations to x4 that must be ignored.
    reset = 1'b0;
    applyStimulus(1'b1, 5'd4, 32'h99, 1'b1, 5'd4);
    for (int k = 1; k <= 31; k++) begin
      #1;
      checkOutput("sweep_init_done", 32'(init_done), 32'd0);
      checkOutput("sweep_read_x5", rdData(0), 32'd0);
      if (k == 10) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      tick;
    end
    checkOutput("sweep_done", 32'(init_done), 32'd1);

    for (int a = 1; a < 32; a++) begin
      setReads(5'(a), 5'(a), 5'(a), 5'(a));
      #1;
      checkOutput("cleared_data", rdData(0), 32'd0);
      checkOutput("cleared_busy", rdBusy(3), 32'd0);
    end

    $display("[TB] x0 write attempt");
    applyStimulus(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0);
    setReads(5'd0, 5'd0, 5'd0, 5'd0);
    #1;
    checkOutput("x0_same_p0", rdData(0), 32'd0);
    checkOutput("x0_same_p1", rdData(1), 32'd0);
    checkOutput("x0_same_busy", rdBusy(0), 32'd0);
    tick;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
    checkOutput("x0_next_p0", rdData(0), 32'd0);
    checkOutput("x0_next_p1", rdData(1), 32'd0);
    checkOutput("x0_next_busy", rdBusy(1), 32'd0);

    $display("[TB] x7 write visibility");
    applyStimulus(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0);
    setReads(5'd7, 5'd0, 5'd0, 5'd0);
    #1;
    checkOutput("x7_same", rdData(0), BYP ? 32'h12345678 : 32'd0);
    tick;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
    checkOutput("x7_next", rdData(0), 32'h12345678);

    $display("[TB] scoreboard");
    setReads(5'd9, 5'd10, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    tick;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
    checkOutput("x9_reserved", rdBusy(0), 32'd1);
    checkOutput("x10_free", rdBusy(1), 32'd0);
    applyStimulus(1'b1, 5'd9, 32'hA5, 1'b0, 5'd0);
    #1;
    checkOutput("x9_wb_same_busy", rdBusy(0), BYP ? 32'd0 : 32'd1);
    checkOutput("x9_wb_same_data", rdData(0), BYP ? 32'hA5 : 32'd0);
    tick;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
    checkOutput("x9_wb_busy", rdBusy(0), 32'd0);
    checkOutput("x9_wb_data", rdData(0), 32'hA5);
    applyStimulus(1'b1, 5'd9, 32'h77, 1'b1, 5'd9);
    #1;
    checkOutput("x9_setclr_same_busy", rdBusy(0), 32'd0);
    checkOutput("x9_setclr_same_data", rdData(0), BYP ? 32'h77 : 32'hA5);
    tick;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
    checkOutput("x9_set_wins", rdBusy(0), 32'd1);
    checkOutput("x9_setclr_data", rdData(0), 32'h77);
    applyStimulus(1'b1, 5'd9, 32'h88, 1'b1, 5'd10);
    #1;
    checkOutput("x9_diff_same_busy", rdBusy(0), BYP ? 32'd0 : 32'd1);
    checkOutput("x10_diff_same_busy", rdBusy(1), 32'd0);
    tick;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
    checkOutput("x9_diff_busy", rdBusy(0), 32'd0);
    checkOutput("x10_diff_busy", rdBusy(1), 32'd1);
    checkOutput("x9_diff_data", rdData(0), 32'h88);

    $display("[TB] four read ports");
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b0, 5'd0);
    tick;
    applyStimulus(1'b1, 5'd31, 32'hFF, 1'b0, 5'd0);
    tick;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    setReads(5'd1, 5'd1, 5'd31, 5'd0);
    #1;
    checkOutput("mp_p0", rdData(0), 32'h11);
    checkOutput("mp_p1", rdData(1), 32'h11);
    checkOutput("mp_p2", rdData(2), 32'hFF);
    checkOutput("mp_p3", rdData(3), 32'd0);
    checkOutput("mp_busy_p0", rdBusy(0), 32'd0);
    checkOutput("mp_busy_p1", rdBusy(1), 32'd0);

    $display("[TB] reset mid-sweep");
    applyStimulus(1'b1, 5'd3, 32'h55, 1'b0, 5'd0);
    tick;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    setReads(5'd3, 5'd10, 5'd7, 5'd0);
    #1;
    checkOutput("x3_written", rdData(0), 32'h55);
    reset = 1'b1;
    #1;
    checkOutput("async_init_done", 32'(init_done), 32'd0);
    checkOutput("async_data", rdData(0), 32'd0);
    checkOutput("async_busy", rdBusy(1), 32'd0);
    tick;
    reset = 1'b0;
    applyStimulus(1'b1, 5'd3, 32'hAB, 1'b1, 5'd3);
    for (int k = 1; k <= 9; k++) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      #1;
      checkOutput("resweep_init_done", 32'(init_done), 32'd0);
      if (k == 10) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      tick;
    end
    checkOutput("resweep_done", 32'(init_done), 32'd1);
    checkOutput("resweep_x3", rdData(0), 32'd0);
    checkOutput("resweep_x3_busy", rdBusy(0), 32'd0);
    checkOutput("resweep_x10_busy", rdBusy(1), 32'd0);
    checkOutput("resweep_x7", rdData(2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
